// File: rtl/fwd_key_expander.sv
// fwd_key_expander: forward AES-128 key schedule that produces the round-10
// key, one round per clock. The result feeds the inverse key-saving chain.
// Optional build macro FWD_KEY_EXPANDER_RK_TAP_EN adds a tap port that
// exposes every intermediate round key as it is generated.
module fwd_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] key10,
  output logic         key10_valid,
  input  logic         key10_ready
`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
  ,
  output logic [127:0] rk_tap,
  output logic [3:0]   rk_tap_idx,
  output logic         rk_tap_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
  endfunction

  // Round constant; counter values outside 1..10 yield zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One forward key-schedule step: previous round key in, next round key out.
  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                   input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, rot, temp;
    logic [31:0] n0, n1, n2, n3;
    w0   = k[127:96];
    w1   = k[95:64];
    w2   = k[63:32];
    w3   = k[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rc, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;

  // Next-state, counter and working-key update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          work_d  = key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        work_d = next_round_key(work_q, rcon(cnt_q));
        if (cnt_q >= LAST_ROUND) begin
          cnt_d   = LAST_ROUND;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (key10_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round counter and working key registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the 128-bit working key is an ordinary register, not a memory,
    // so it is reset to give key10 a deterministic value after reset.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      work_q  <= 128'h0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // values present before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    key_ready   = (state_q == IDLE);
    key10_valid = (state_q == DONE);
    key10       = work_q;
  end

`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
  logic [127:0] rk_tap_q, rk_tap_d;
  logic [3:0]   rk_tap_idx_q, rk_tap_idx_d;
  logic         rk_tap_valid_q, rk_tap_valid_d;

  // Tap captures each round key as it is written into the working register.
  always_comb begin
    rk_tap_valid_d = (state_q == EXPAND);
    rk_tap_d       = rk_tap_valid_d ? work_d : rk_tap_q;
    rk_tap_idx_d   = rk_tap_valid_d ? cnt_q : rk_tap_idx_q;
  end

  // Tap output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_tap_q       <= 128'h0;
      rk_tap_idx_q   <= 4'd0;
      rk_tap_valid_q <= 1'b0;
    end else begin
      rk_tap_q       <= rk_tap_d;
      rk_tap_idx_q   <= rk_tap_idx_d;
      rk_tap_valid_q <= rk_tap_valid_d;
    end
  end

  assign rk_tap       = rk_tap_q;
  assign rk_tap_idx   = rk_tap_idx_q;
  assign rk_tap_valid = rk_tap_valid_q;
`endif

endmodule

// File: tb/tb_fwd_key_expander.sv
// tb_fwd_key_expander: directed, table-driven bench for fwd_key_expander.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fwd_key_expander;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_KEY   = 128'h0;
  localparam logic [127:0] ZERO_K10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  // Valid is first seen in the cycle that starts 10 edges after the accept
  // edge, i.e. the 11th cycle counting the accept cycle.
  localparam int           EXP_LAT    = 10;
  localparam int           WAIT_BOUND = 40;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key10;
  logic         key10_valid;
  logic         key10_ready;
`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
  logic [127:0] rk_tap;
  logic [3:0]   rk_tap_idx;
  logic         rk_tap_valid;
`endif

  int total = 0;
  int bad   = 0;

  fwd_key_expander dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key10       (key10),
    .key10_valid (key10_valid),
    .key10_ready (key10_ready)
`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
    ,
    .rk_tap      (rk_tap),
    .rk_tap_idx  (rk_tap_idx),
    .rk_tap_valid(rk_tap_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
  int           tap_cnt = 0;
  logic [127:0] tap1    = '0;
  logic [127:0] tap10   = '0;
  always @(negedge clk) begin
    if (rk_tap_valid) begin
      tap_cnt++;
      if (rk_tap_idx == 4'd1)  tap1  = rk_tap;
      if (rk_tap_idx == 4'd10) tap10 = rk_tap;
    end
  end
`endif

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for key10_valid; returns the number of falling edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!key10_valid && lat < WAIT_BOUND) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Offer one key (caller is at a falling edge), check latency, result and
  // a hold of 'hold' cycles with key10_ready low, then complete the handshake.
  task automatic run_key(input string tag, input logic [127:0] key,
                         input logic [127:0] exp, input int hold);
    int lat;
    key_in      = key;
    key_valid   = 1'b1;
    key10_ready = (hold == 0);
    check({tag, "_ready_idle"}, key_ready, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    check({tag, "_busy"}, key_ready, 1'b0);
    wait_valid(lat);
    check({tag, "_latency"}, lat, EXP_LAT);
    check({tag, "_key10"}, key10, exp);
    for (int i = 0; i < hold; i++) begin
      key_valid = (i % 2 == 0);
      key_in    = ~key;
      @(negedge clk);
      check({tag, "_hold_valid"}, key10_valid, 1'b1);
      check({tag, "_hold_key10"}, key10, exp);
      check({tag, "_hold_kready"}, key_ready, 1'b0);
    end
    key_valid   = 1'b0;
    key10_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, key10_valid, 1'b0);
    check({tag, "_post_kready"}, key_ready, 1'b1);
    key10_ready = 1'b0;
  endtask

  typedef struct {
    string        tag;
    logic [127:0] key;
    logic [127:0] exp;
    int           hold;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat;
    vecs[0] = '{tag: "fips",      key: FIPS_KEY, exp: FIPS_K10, hold: 0};
    vecs[1] = '{tag: "zero_hold", key: ZERO_KEY, exp: ZERO_K10, hold: 5};
    vecs[2] = '{tag: "fips_hold", key: FIPS_KEY, exp: FIPS_K10, hold: 2};

    rst_n       = 1'b0;
    key_in      = '0;
    key_valid   = 1'b0;
    key10_ready = 1'b0;
    #2;
    check("reset_key_ready", key_ready, 1'b1);
    check("reset_valid", key10_valid, 1'b0);
    check("reset_key10", key10, 128'h0);

    // Release reset on a falling edge and offer a key immediately.
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 3; v++) begin
`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
      tap_cnt = 0;
`endif
      run_key(vecs[v].tag, vecs[v].key, vecs[v].exp, vecs[v].hold);
`ifdef FWD_KEY_EXPANDER_RK_TAP_EN
      check({vecs[v].tag, "_tap_cnt"}, tap_cnt, 10);
      if (v == 0) begin
        check("tap_idx1", tap1, FIPS_K1);
        check("tap_idx10", tap10, FIPS_K10);
      end
`endif
    end

    // Reset after round 5, then reload on the first edge after release.
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_key_ready", key_ready, 1'b1);
    check("midrst_valid", key10_valid, 1'b0);
    check("midrst_key10", key10, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_key("after_rst", FIPS_KEY, FIPS_K10, 0);

    // Back-to-back: key_valid held high across the first handshake.
    key_in      = FIPS_KEY;
    key_valid   = 1'b1;
    key10_ready = 1'b1;
    @(negedge clk);
    key_in = ZERO_KEY;
    wait_valid(lat);
    check("b2b_lat1", lat, EXP_LAT);
    check("b2b_key10_1", key10, FIPS_K10);
    @(negedge clk);
    check("b2b_bubble_valid", key10_valid, 1'b0);
    check("b2b_bubble_kready", key_ready, 1'b1);
    @(negedge clk);
    check("b2b_second_accept", key_ready, 1'b0);
    key_valid = 1'b0;
    wait_valid(lat);
    check("b2b_lat2", lat, EXP_LAT);
    check("b2b_key10_2", key10, ZERO_K10);
    @(negedge clk);
    check("b2b_end_valid", key10_valid, 1'b0);
    key10_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_valid", key10_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
